aes_stream_ctrl: RTL
====================

Name: aes_stream_ctrl

Overview:
Parametrised stream front-end for the AES core. It queues blocks arriving on a valid/ready input stream into a DEPTH-entry FIFO and issues them to the core one at a time with a single-cycle Enable pulse. It captures Data_Out on Data_Out_VLD and presents the result, together with its tag, on a valid/ready output stream. It sits between the system bus adapter and the AES core, and replaces direct Enable/Data_In driving of the core.

Parameters:
DATA_W, 128, block width in bits
KEY_W, 128, key width in bits (128/192/256, passed through to the core)
TAG_W, 4, width of the user tag carried with each block
DEPTH, 4, input FIFO entries (power of two, >=2)
TIMEOUT, 64, max cycles in WAIT before error completion (>=2)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
S_Valid  in  1  input block valid
S_Ready  out  1  input FIFO can accept
S_Data  in  DATA_W  plaintext block
S_Key  in  KEY_W  key for this block
S_Tag  in  TAG_W  user tag
Core_Enable  out  1  one-cycle start pulse to the core
Core_Data_In  out  DATA_W  block to the core
Core_Key  out  KEY_W  key to the core
Core_Data_Out  in  DATA_W  core result
Core_Data_Out_VLD  in  1  core result valid
M_Valid  out  1  result valid
M_Ready  in  1  downstream accepts
M_Data  out  DATA_W  result block
M_Tag  out  TAG_W  tag of the result
M_Err  out  1  result is a timeout completion
Busy  out  1  FIFO non-empty, or FSM not IDLE, or M_Valid
Fill  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (RST=0, async): FIFO empty, Fill=0, FSM=IDLE, and every registered output is 0: Core_Enable, Core_Data_In, Core_Key, M_Valid, M_Data, M_Tag, M_Err, Busy. S_Ready is 1 after reset.
- S_Ready = !full, taken from registered occupancy.
- Push when S_Valid && S_Ready. A push while full cannot happen, even if a pop occurs in the same cycle.
- Simultaneous push and pop leaves Fill unchanged.
- FIFO pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT.
- IDLE -> WAIT when the FIFO is non-empty and the output slot is free (M_Valid=0, or M_Valid && M_Ready this cycle). On that edge:
  - pop the head;
  - register head data/key/tag into Core_Data_In/Core_Key/tag register;
  - Core_Enable=1 for exactly one cycle.
- Latency: a block pushed at edge t produces Core_Enable high during cycle t+1..t+2 if the controller is idle.
- Core_Data_In and Core_Key hold stable from the Enable cycle until WAIT exits.
- WAIT: Core_Data_Out_VLD is sampled in every WAIT cycle, including the Enable cycle. On VLD:
  - M_Data <= Core_Data_Out, M_Tag <= held tag, M_Err <= 0, M_Valid <= 1;
  - FSM -> IDLE.
- Only one block is outstanding at the core at a time. Results come out in input order.
- M_Valid stays high, with M_Data/M_Tag/M_Err stable, until M_Ready. It clears on the handshake edge unless a new result loads on the same edge.
- Core_Data_Out_VLD in IDLE is ignored.
- Cycle counter: cleared on WAIT entry, increments each WAIT cycle, saturates. Its behaviour on reaching TIMEOUT is set by the optional feature.
- Reset mid-WAIT abandons the in-flight block; the core shares RST.

Optional Feature:
AES_STREAM_TIMEOUT_EN:
- Defined: when the counter reaches TIMEOUT without VLD, the block completes with M_Data=0, M_Err=1, M_Tag=held tag, and the FSM returns to IDLE. A VLD arriving later is ignored.
- Undefined: WAIT persists until VLD; M_Err is tied to 0; the counter logic is removed.

Decomposition:
- Package aes_stream_pkg: state enum (IDLE, WAIT), default widths (DATA_W, KEY_W, TAG_W), and a packed struct of {data, key, tag} used as the FIFO entry.
- One sub-module: aes_stream_fifo, a synchronous DEPTH-entry FIFO with full/empty/count and async active-low reset.

Test Plan:
1. Single block with FIPS-197 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, tag 3 -> exactly one Core_Enable pulse; M_Data=69c4e0d86a7b0430d8cdb78070b4c55a, M_Tag=3, M_Err=0.
2. DEPTH=4, core stalled in WAIT, 6 back-to-back pushes -> 1 issued plus 4 queued; S_Ready=0 with Fill=4; remaining pushes held until a pop; results emerge in tag order.
3. M_Ready=0 for 20 cycles with 2 queued -> M_Valid and M_Data stable throughout; no second Core_Enable until the handshake, then issue on the same edge.
4. Timeout enabled, TIMEOUT=64, core never asserts VLD -> M_Valid with M_Err=1, M_Data=0 exactly 64 cycles after Enable; VLD at cycle 70 ignored; next block issues normally.
5. RST low for 3 cycles during WAIT with Fill=2 -> all outputs 0, Fill=0, S_Ready=1; a later VLD produces no M_Valid.
6. Spurious Core_Data_Out_VLD in IDLE with an empty FIFO -> no M_Valid, Busy stays 0.

Source files
------------

// File: rtl/aes_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_stream_pkg
// Description : Shared types for the AES stream controller: controller state
//               encoding, default widths and the default FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_stream_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_KEY_W  = 128;
    localparam int DEF_TAG_W  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // One queued block: plaintext, its key and the user tag travelling with it.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_KEY_W-1:0]  key;
        logic [DEF_TAG_W-1:0]  tag;
    } stream_entry_t;

endpackage
`default_nettype wire

// File: rtl/aes_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_stream_ctrl_if
// Description : Input stream, output stream and AES core signals of the
//               stream controller. 'slave' is the controller's view,
//               'master' is the surrounding system's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_stream_ctrl_if
    import aes_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int KEY_W  = DEF_KEY_W,
    parameter int TAG_W  = DEF_TAG_W
);
    logic              S_Valid;
    logic              S_Ready;
    logic [DATA_W-1:0] S_Data;
    logic [KEY_W-1:0]  S_Key;
    logic [TAG_W-1:0]  S_Tag;

    logic              Core_Enable;
    logic [DATA_W-1:0] Core_Data_In;
    logic [KEY_W-1:0]  Core_Key;
    logic [DATA_W-1:0] Core_Data_Out;
    logic              Core_Data_Out_VLD;

    logic              M_Valid;
    logic              M_Ready;
    logic [DATA_W-1:0] M_Data;
    logic [TAG_W-1:0]  M_Tag;
    logic              M_Err;

    modport slave (
        input  S_Valid, S_Data, S_Key, S_Tag, Core_Data_Out, Core_Data_Out_VLD, M_Ready,
        output S_Ready, Core_Enable, Core_Data_In, Core_Key, M_Valid, M_Data, M_Tag, M_Err
    );

    modport master (
        output S_Valid, S_Data, S_Key, S_Tag, Core_Data_Out, Core_Data_Out_VLD, M_Ready,
        input  S_Ready, Core_Enable, Core_Data_In, Core_Key, M_Valid, M_Data, M_Tag, M_Err
    );
endinterface
`default_nettype wire

// File: rtl/aes_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aes_stream_fifo
// Description : Synchronous DEPTH-entry FIFO (DEPTH a power of two) with
//               full/empty/count. Push while full and pop while empty are
//               dropped. Head entry is readable combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_stream_fifo
    import aes_stream_pkg::*;
#(
    parameter type entry_t = stream_entry_t,
    parameter int  DEPTH   = 4
)(
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    output entry_t                       pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    entry_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    // Full is judged on the registered count, so a pop cannot make room for
    // a push in the same cycle.
    assign full     = (r_count == c_FULL);
    assign empty    = (r_count == '0);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

    // Storage array; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - c_CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/aes_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_stream_ctrl
// Description : Stream front-end for the AES core. Queues input blocks,
//               issues them one at a time with a single-cycle Core_Enable,
//               and returns results with their tag on an output stream.
//               Optional feature macro: AES_STREAM_TIMEOUT_EN (completes a
//               block with M_Err=1, M_Data=0 after TIMEOUT WAIT cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_stream_ctrl
    import aes_stream_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int KEY_W   = DEF_KEY_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
)(
    input  logic                         CLK,
    input  logic                         RST,
    aes_stream_ctrl_if.slave             bus,
    output logic                         Busy,
    output logic [$clog2(DEPTH+1)-1:0]   Fill
);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEY_W-1:0]  key;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t              w_push_entry;
    entry_t              w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic [c_CNT_W-1:0]  w_count;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_issue;
    logic                w_done;
    logic                w_err_done;
    logic                w_timeout;
    logic                w_m_valid_next;
    logic                w_fifo_busy_next;

    logic                r_enable;
    logic [DATA_W-1:0]   r_core_data;
    logic [KEY_W-1:0]    r_core_key;
    logic [TAG_W-1:0]    r_tag;
    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    logic [TAG_W-1:0]    r_m_tag;
    logic                r_m_err;
    logic                r_busy;

    assign w_push_entry = '{data: bus.S_Data, key: bus.S_Key, tag: bus.S_Tag};
    assign w_push       = bus.S_Valid && !w_full;

    aes_stream_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_issue),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

`ifdef AES_STREAM_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    logic [c_TO_W-1:0] r_wait_cnt;

    // The count is 0 in the Enable cycle, so the TIMEOUT-th WAIT cycle is the last one.
    assign w_timeout = (r_state == WAIT) && (r_wait_cnt == c_TO_LAST);

    // WAIT cycle counter: cleared on entry, saturates at its last value.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wait_cnt <= '0;
        end else if (w_issue) begin
            r_wait_cnt <= '0;
        end else if ((r_state == WAIT) && (r_wait_cnt != c_TO_LAST)) begin
            r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state: issue when a block is queued and the result slot is free or
    // being freed this cycle; complete on VLD (or on timeout when enabled).
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        w_err_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && (!r_m_valid || bus.M_Ready)) begin
                    w_issue      = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus.Core_Data_Out_VLD) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end else if (w_timeout) begin
                    w_done       = 1'b1;
                    w_err_done   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Busy is registered from the next-cycle view of FIFO, FSM and output slot.
    assign w_m_valid_next   = w_done || (r_m_valid && !bus.M_Ready);
    assign w_fifo_busy_next = w_push || (w_count > c_CNT_W'(1)) ||
                              ((w_count == c_CNT_W'(1)) && !w_issue);

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    // Issue path: one-cycle Enable pulse; block and tag held until the next issue.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_enable    <= 1'b0;
            r_core_data <= '0;
            r_core_key  <= '0;
            r_tag       <= '0;
        end else begin
            r_enable <= w_issue;
            if (w_issue) begin
                r_core_data <= w_head.data;
                r_core_key  <= w_head.key;
                r_tag       <= w_head.tag;
            end
        end
    end

    // Result slot: a new result has priority over the handshake clearing M_Valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_tag   <= '0;
            r_m_err   <= 1'b0;
        end else if (w_done) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_err_done ? '0 : bus.Core_Data_Out;
            r_m_tag   <= r_tag;
            r_m_err   <= w_err_done;
        end else if (r_m_valid && bus.M_Ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Registered activity flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_busy <= 1'b0;
        else      r_busy <= w_fifo_busy_next || (w_next_state != IDLE) || w_m_valid_next;
    end

    assign bus.S_Ready      = !w_full;
    assign bus.Core_Enable  = r_enable;
    assign bus.Core_Data_In = r_core_data;
    assign bus.Core_Key     = r_core_key;
    assign bus.M_Valid      = r_m_valid;
    assign bus.M_Data       = r_m_data;
    assign bus.M_Tag        = r_m_tag;
    assign bus.M_Err        = r_m_err;
    assign Busy             = r_busy;
    assign Fill             = w_count;
endmodule
`default_nettype wire
